// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode mnemonics, sequencer states and
// instruction field positions (also used by assembler-facing benches).
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        kADD = 4'd0,
        kSUB = 4'd1,
        kAND = 4'd2,
        kXOR = 4'd3,
        kLDR = 4'd4,
        kLDI = 4'd5,
        kSHL = 4'd6,
        kSHR = 4'd7,
        kNOT = 4'd8,
        kCLR = 4'd9,
        kSTR = 4'd10,
        kMST = 4'd11,
        kMLD = 4'd12,
        kJMP = 4'd13,
        kBRZ = 4'd14,
        kBRN = 4'd15
    } op_mne;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StMemWait,
        StDone
    } seq_state_e;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned OP_MSB  = 8;
    localparam int unsigned OP_LSB  = 5;
    localparam int unsigned IMM_W   = 5;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's external buses: instruction ROM, data RAM and the ALU.
interface alu_sequencer_if #(
    parameter int unsigned PC_W = 8
);
    logic [PC_W-1:0]                      im_addr;
    logic [alu_sequencer_pkg::INSTR_W-1:0] im_data;
    logic [7:0]                           dm_addr;
    logic [7:0]                           dm_wdata;
    logic                                 dm_we;
    logic [7:0]                           dm_rdata;
    logic [3:0]                           alu_op;
    logic [7:0]                           alu_a;
    logic [7:0]                           alu_acc;
    logic                                 alu_ci;
    logic [7:0]                           alu_res;
    logic                                 alu_co;
    logic                                 alu_neg;

    modport master (
        output im_addr, dm_addr, dm_wdata, dm_we, alu_op, alu_a, alu_acc, alu_ci,
        input  im_data, dm_rdata, alu_res, alu_co, alu_neg
    );

    modport slave (
        input  im_addr, dm_addr, dm_wdata, dm_we, alu_op, alu_a, alu_acc, alu_ci,
        output im_data, dm_rdata, alu_res, alu_co, alu_neg
    );

endinterface

// File: rtl/alu_sequencer_reg_file.sv
// 8-bit register file: one combinational read port, one synchronous write port.
module alu_sequencer_reg_file #(
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    localparam int Depth = 2 ** AW;

    logic [7:0] regs_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external ALU: fetch/decode, accumulator and flags,
// PC and branches, register file and data-memory traffic.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     RF_AW    = 3,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    alu_sequencer_if.master        bus,
    output logic [7:0]             acc_q_o,
    output logic                   done_o
);
    localparam logic [PC_W-1:0] PcOne = PC_W'(1);

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, pc_inc, pc_off;
    logic [7:0]       acc_q, acc_d;
    logic             co_q, co_d, z_q, z_d, neg_q, neg_d;

    op_mne            op;
    logic [IMM_W-1:0] imm;
    logic [RF_AW-1:0] idx;
    logic [7:0]       rf_rdata;
    logic             rf_we;

    logic [3:0]       alu_op;
    logic [7:0]       alu_a;
    logic             alu_ci;
    logic [7:0]       dm_addr;
    logic             dm_we;

    assign op     = op_mne'(bus.im_data[OP_MSB:OP_LSB]);
    assign imm    = bus.im_data[IMM_W-1:0];
    assign idx    = imm[RF_AW-1:0];
    assign pc_inc = pc_q + PcOne;
    assign pc_off = pc_q + {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};

    alu_sequencer_reg_file #(
        .AW(RF_AW)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rf_we),
        .waddr_i (idx),
        .wdata_i (acc_q),
        .raddr_i (idx),
        .rdata_o (rf_rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        co_d    = co_q;
        z_d     = z_q;
        neg_d   = neg_q;
        alu_op  = kCLR;
        alu_a   = '0;
        alu_ci  = 1'b0;
        dm_addr = '0;
        dm_we   = 1'b0;
        rf_we   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRun;
                    pc_d    = START_PC;
                end
            end
            StRun: begin
                alu_op = op;
                pc_d   = pc_inc;
                unique case (op)
                    kADD, kSUB: begin
                        alu_a  = rf_rdata;
                        alu_ci = (op == kADD) ? co_q : 1'b0;
                        acc_d  = bus.alu_res;
                        z_d    = (bus.alu_res == 8'd0);
                        co_d   = bus.alu_co;
                        neg_d  = bus.alu_neg;
                    end
                    kAND, kXOR, kLDR, kLDI, kSHR, kNOT: begin
                        if (op == kLDI) begin
                            alu_a = 8'(imm);
                        end else if (op == kSHR) begin
                            alu_a = {5'b0, imm[2:0]};
                        end else if (op != kNOT) begin
                            alu_a = rf_rdata;
                        end
                        acc_d = bus.alu_res;
                        z_d   = (bus.alu_res == 8'd0);
                    end
                    kSHL: begin
                        alu_a = {5'b0, imm[2:0]};
                        acc_d = bus.alu_res;
                        z_d   = (bus.alu_res == 8'd0);
                        co_d  = bus.alu_co;
                    end
                    kCLR: begin
                        acc_d = '0;
                        co_d  = 1'b0;
                        z_d   = 1'b0;
                        neg_d = 1'b0;
                    end
                    kSTR: rf_we = 1'b1;
                    kMST: begin
                        dm_addr = rf_rdata;
                        dm_we   = 1'b1;
                    end
                    kMLD: begin
                        // Address goes out now; the RAM answers next cycle in StMemWait.
                        dm_addr = rf_rdata;
                        state_d = StMemWait;
                        pc_d    = pc_q;
                    end
                    kJMP: begin
                        if (imm == '0) begin
                            state_d = StDone;
                            pc_d    = pc_q;
                        end else begin
                            pc_d = pc_off;
                        end
                    end
                    kBRZ: if (z_q) pc_d = pc_off;
                    kBRN: if (neg_q) pc_d = pc_off;
                endcase
            end
            StMemWait: begin
                acc_d   = bus.dm_rdata;
                z_d     = (bus.dm_rdata == 8'd0);
                pc_d    = pc_inc;
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= START_PC;
            acc_q   <= '0;
            co_q    <= 1'b0;
            z_q     <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            co_q    <= co_d;
            z_q     <= z_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.im_addr  = pc_q;
    assign bus.dm_addr  = dm_addr;
    assign bus.dm_wdata = acc_q;
    assign bus.dm_we    = dm_we;
    assign bus.alu_op   = alu_op;
    assign bus.alu_a    = alu_a;
    assign bus.alu_acc  = acc_q;
    assign bus.alu_ci   = alu_ci;
    assign acc_q_o      = acc_q;
    assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, ROM and sync-read RAM around the DUT,
// a table of short programs plus hand-written memory/done/wrap/reset sequences.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int unsigned PC_W = 8;
    localparam int NV = 13;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] acc_q;
    logic       done;

    alu_sequencer_if #(.PC_W(PC_W)) bus ();

    alu_sequencer #(
        .PC_W     (PC_W),
        .RF_AW    (3),
        .START_PC (8'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bus     (bus),
        .acc_q_o (acc_q),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [256];
    logic [7:0] ram [256];
    logic [7:0] ram_rdata;

    assign bus.im_data  = rom[bus.im_addr];
    assign bus.dm_rdata = ram_rdata;

    always @(posedge clk) begin
        if (bus.dm_we) ram[bus.dm_addr] <= bus.dm_wdata;
        ram_rdata <= ram[bus.dm_addr];
    end

    // ALU model: SUB carry is borrow, SHL carry is the last bit shifted out.
    logic [8:0]  sum;
    logic [15:0] shl;
    always_comb begin
        sum         = {1'b0, bus.alu_acc} + {1'b0, bus.alu_a} + {8'b0, bus.alu_ci};
        shl         = {8'b0, bus.alu_acc} << bus.alu_a[2:0];
        bus.alu_res = 8'h00;
        bus.alu_co  = 1'b0;
        case (bus.alu_op)
            4'(kADD): begin bus.alu_res = sum[7:0]; bus.alu_co = sum[8]; end
            4'(kSUB): begin
                bus.alu_res = bus.alu_acc - bus.alu_a;
                bus.alu_co  = (bus.alu_acc < bus.alu_a);
            end
            4'(kAND): bus.alu_res = bus.alu_acc & bus.alu_a;
            4'(kXOR): bus.alu_res = bus.alu_acc ^ bus.alu_a;
            4'(kLDR), 4'(kLDI): bus.alu_res = bus.alu_a;
            4'(kSHL): begin bus.alu_res = shl[7:0]; bus.alu_co = shl[8]; end
            4'(kSHR): bus.alu_res = bus.alu_acc >> bus.alu_a[2:0];
            4'(kNOT): bus.alu_res = ~bus.alu_acc;
            default: bus.alu_res = 8'h00;
        endcase
        bus.alu_neg = bus.alu_res[7];
    end

    typedef struct {
        int         cycles;
        logic [7:0] acc;
        logic       co;
        logic       z;
        logic       neg;
        logic [7:0] pc;
        logic       done;
    } vec_t;

    vec_t       vecs  [NV];
    logic [8:0] progs [NV][6];
    logic [8:0] hlt;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [8:0] ins(input op_mne o, input logic [4:0] imm);
        return {o, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = hlt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_mem_prog();
        clear_rom();
        rom[0] = ins(kLDI, 5'd7);
        rom[1] = ins(kSTR, 5'd2);
        rom[2] = ins(kLDI, 5'd20);
        rom[3] = ins(kMST, 5'd2);
        rom[4] = ins(kCLR, 5'd0);
        rom[5] = ins(kMLD, 5'd2);
    endtask

    initial begin
        hlt = ins(kJMP, 5'd0);

        progs[0]  = '{ins(kLDI, 5), ins(kSTR, 1), ins(kLDI, 3), ins(kADD, 1), hlt, hlt};
        progs[1]  = '{ins(kLDI, 31), ins(kSHL, 3), hlt, hlt, hlt, hlt};
        progs[2]  = '{ins(kLDI, 31), ins(kSHL, 3), ins(kSHL, 1), hlt, hlt, hlt};
        progs[3]  = '{ins(kCLR, 0), ins(kLDI, 0), ins(kBRZ, 3), hlt, hlt, ins(kBRN, 3)};
        progs[4]  = progs[3];
        progs[5]  = '{ins(kLDI, 3), ins(kSTR, 0), ins(kLDI, 1), ins(kSUB, 0), hlt, hlt};
        progs[6]  = '{ins(kLDI, 31), ins(kSTR, 1), ins(kSHL, 3), ins(kADD, 1), ins(kADD, 1), hlt};
        progs[7]  = progs[6];
        progs[8]  = '{ins(kLDI, 12), ins(kSTR, 3), ins(kLDI, 10), ins(kXOR, 3), ins(kNOT, 0),
                      ins(kSHR, 2)};
        progs[9]  = '{ins(kLDI, 9), ins(kSTR, 7), ins(kLDI, 3), ins(kAND, 7), ins(kLDR, 7), hlt};
        progs[10] = '{ins(kLDI, 6), ins(kSTR, 4), ins(kLDI, 9), ins(kAND, 4), hlt, hlt};
        progs[11] = '{ins(kLDI, 2), hlt, hlt, hlt, hlt, hlt};
        progs[12] = '{ins(kJMP, 31), hlt, hlt, hlt, hlt, hlt};

        //            cyc  acc    co    z     neg   pc     done
        vecs[0]  = '{4, 8'h08, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0};
        vecs[1]  = '{2, 8'hF8, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0};
        vecs[2]  = '{3, 8'hF0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0};
        vecs[3]  = '{3, 8'h00, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0};
        vecs[4]  = '{4, 8'h00, 1'b0, 1'b1, 1'b0, 8'd6, 1'b0};
        vecs[5]  = '{4, 8'hFE, 1'b1, 1'b0, 1'b1, 8'd4, 1'b0};
        vecs[6]  = '{4, 8'h17, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0};
        vecs[7]  = '{5, 8'h37, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0};
        vecs[8]  = '{6, 8'h3E, 1'b0, 1'b0, 1'b0, 8'd6, 1'b0};
        vecs[9]  = '{5, 8'h09, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0};
        vecs[10] = '{4, 8'h00, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0};
        vecs[11] = '{2, 8'h02, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        vecs[12] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};

        clear_rom();

        // Reset values while reset is held from time 0
        @(negedge clk);
        chk("rst acc", 32'(acc_q), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst pc", 32'(bus.im_addr), 32'h0);
        chk("rst dm_we", 32'(bus.dm_we), 32'h0);
        chk("rst alu_op", 32'(bus.alu_op), 32'(kCLR));
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            do_reset();
            clear_rom();
            for (int k = 0; k < 6; k++) rom[k] = progs[v][k];
            go();
            run(vecs[v].cycles);
            chk($sformatf("v%0d acc", v), 32'(acc_q), 32'(vecs[v].acc));
            chk($sformatf("v%0d co", v), 32'(dut.co_q), 32'(vecs[v].co));
            chk($sformatf("v%0d z", v), 32'(dut.z_q), 32'(vecs[v].z));
            chk($sformatf("v%0d neg", v), 32'(dut.neg_q), 32'(vecs[v].neg));
            chk($sformatf("v%0d pc", v), 32'(bus.im_addr), 32'(vecs[v].pc));
            chk($sformatf("v%0d done", v), 32'(done), 32'(vecs[v].done));
        end

        // MST then MLD through the sync-read RAM
        do_reset();
        load_mem_prog();
        go();
        run(3);
        chk("mst we", 32'(bus.dm_we), 32'h1);
        chk("mst addr", 32'(bus.dm_addr), 32'h7);
        chk("mst data", 32'(bus.dm_wdata), 32'h14);
        run(1);
        chk("mst we drop", 32'(bus.dm_we), 32'h0);
        run(1);
        chk("mld acc pre", 32'(acc_q), 32'h0);
        chk("mld addr", 32'(bus.dm_addr), 32'h7);
        run(1);
        chk("mld wait pc", 32'(bus.im_addr), 32'h5);
        chk("mld wait acc", 32'(acc_q), 32'h0);
        chk("mld wait we", 32'(bus.dm_we), 32'h0);
        run(1);
        chk("mld acc", 32'(acc_q), 32'h14);
        chk("mld pc", 32'(bus.im_addr), 32'h6);
        chk("mld z", 32'(dut.z_q), 32'h0);

        // DONE holds; start restarts; start ignored while running
        do_reset();
        clear_rom();
        rom[0] = ins(kLDI, 5'd2);
        go();
        run(2);
        chk("halt done", 32'(done), 32'h1);
        chk("halt pc", 32'(bus.im_addr), 32'h1);
        run(3);
        chk("halt done hold", 32'(done), 32'h1);
        chk("halt pc hold", 32'(bus.im_addr), 32'h1);
        chk("halt alu_op", 32'(bus.alu_op), 32'(kCLR));
        go();
        chk("restart pc", 32'(bus.im_addr), 32'h0);
        chk("restart done", 32'(done), 32'h0);
        chk("restart acc", 32'(acc_q), 32'h2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start in run pc", 32'(bus.im_addr), 32'h1);
        run(1);
        chk("rehalt done", 32'(done), 32'h1);

        // PC wraps 0 -> 255 backwards and 255 -> 0 forwards
        do_reset();
        clear_rom();
        rom[0]   = ins(kJMP, 5'd31);
        rom[255] = ins(kLDI, 5'd9);
        go();
        run(1);
        chk("wrap back pc", 32'(bus.im_addr), 32'hFF);
        run(1);
        chk("wrap fwd pc", 32'(bus.im_addr), 32'h0);
        chk("wrap acc", 32'(acc_q), 32'h9);

        // Reset while MLD waits for RAM data
        do_reset();
        load_mem_prog();
        go();
        run(6);
        chk("mw state", 32'(dut.state_q), 32'(StMemWait));
        rst = 1'b1;
        #1;
        chk("mw rst state", 32'(dut.state_q), 32'(StIdle));
        chk("mw rst acc", 32'(acc_q), 32'h0);
        chk("mw rst pc", 32'(bus.im_addr), 32'h0);
        chk("mw rst we", 32'(bus.dm_we), 32'h0);
        chk("mw rst dm_addr", 32'(bus.dm_addr), 32'h0);
        chk("mw rst done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("mw rst hold acc", 32'(acc_q), 32'h0);
        run(2);
        chk("idle pc", 32'(bus.im_addr), 32'h0);
        chk("idle acc", 32'(acc_q), 32'h0);
        chk("idle state", 32'(dut.state_q), 32'(StIdle));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
